// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM/ROM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_arb_pkg;

    localparam int SRAM_ARB_CNT_W          = 4;
    localparam int SRAM_ARB_ACCESS_CYC_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        WR_REC,
        DONE
    } sram_arb_state_t;

endpackage

// File: rtl/sram_arb_cache.sv
// Single-entry read cache: holds the last SRAM read address/data for the CPU port.
// Latency: hit is combinational on lookup_addr; fill/invalidate take effect next cycle.
// Backpressure: none; invalidate wins over a same-cycle fill.
//
// Ports: clk_sys/reset (async, active-high); lookup_addr -> hit/hit_data;
//        fill + fill_addr/fill_data load the entry; invalidate clears valid.
module sram_arb_cache #(
    parameter int ADDR_W = 19
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr,
    input  logic              fill,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [7:0]        fill_data,
    input  logic              invalidate,
    output logic              hit,
    output logic [7:0]        hit_data
);

    logic              valid;
    logic [ADDR_W-1:0] tag;
    logic [7:0]        data;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (invalidate) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_addr;
            data  <= fill_data;
        end
    end

    assign hit      = valid && (tag == lookup_addr);
    assign hit_data = data;

endmodule

// File: rtl/sram_rom_arbiter.sv
// Arbiter/sequencer sharing an async SRAM between ROM download writes and CPU reads.
// Latency: read ack n+ACCESS_CYC+1, write ack n+ACCESS_CYC+2 (cache hit: n+1).
// Backpressure: level req held until one-cycle ack; download wins, CPU waits while dl_active.
//
// Ports: clk_sys/reset (async, active-high); dl_* download write port; cpu_* read port;
//        sram_* registered SRAM pins (tristate lives in the top level).
// Option: define SRAM_ARB_CACHE_EN for a single-entry CPU read cache.
module sram_rom_arbiter
    import sram_arb_pkg::*;
#(
    parameter int                ADDR_W     = 19,
    parameter int                CPU_W      = 16,
    parameter logic [ADDR_W-1:0] CPU_BASE   = '0,
    parameter int                ACCESS_CYC = SRAM_ARB_ACCESS_CYC_DEF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dl_active,
    input  logic              dl_req,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_wdata,
    output logic              dl_ack,
    input  logic              cpu_req,
    input  logic [CPU_W-1:0]  cpu_addr,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [7:0]        sram_data_o,
    output logic              sram_data_oe,
    input  logic [7:0]        sram_data_i,
    output logic              sram_we_n_o,
    output logic              sram_oe_n_o
);

    // Counter holds remaining strobe cycles minus one; zero marks the last cycle.
    localparam logic [SRAM_ARB_CNT_W-1:0] CNT_LOAD = SRAM_ARB_CNT_W'(ACCESS_CYC - 1);

    sram_arb_state_t            state, state_n;
    logic [SRAM_ARB_CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0]          addr_n;
    logic [7:0]                 wdata_n;
    logic [7:0]                 rdata_n;
    logic [ADDR_W-1:0]          cpu_sram_addr;
    logic                       cache_hit;
    logic [7:0]                 cache_data;

    // Zero-extend then add; the sum wraps inside the SRAM address space.
    assign cpu_sram_addr = ADDR_W'(cpu_addr) + CPU_BASE;

`ifdef SRAM_ARB_CACHE_EN
    logic dl_active_q;
    logic cache_fill;
    logic cache_inval;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) dl_active_q <= 1'b0;
        else       dl_active_q <= dl_active;
    end

    // Fill on the cycle the SRAM data is captured; sram_addr_o still holds the read address.
    assign cache_fill  = (state == RD) && (cnt == '0);
    assign cache_inval = ((state == IDLE) && dl_req) || (dl_active && !dl_active_q);

    sram_arb_cache #(
        .ADDR_W (ADDR_W)
    ) u_cache (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .lookup_addr (cpu_sram_addr),
        .fill        (cache_fill),
        .fill_addr   (sram_addr_o),
        .fill_data   (sram_data_i),
        .invalidate  (cache_inval),
        .hit         (cache_hit),
        .hit_data    (cache_data)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = 8'h00;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = sram_addr_o;
        wdata_n = sram_data_o;
        rdata_n = cpu_rdata;
        case (state)
            IDLE: begin
                if (dl_req) begin
                    state_n = WR;
                    cnt_n   = CNT_LOAD;
                    addr_n  = dl_addr;
                    wdata_n = dl_wdata;
                end else if (cpu_req && !dl_active) begin
                    addr_n = cpu_sram_addr;
                    if (cache_hit) begin
                        state_n = DONE;
                        rdata_n = cache_data;
                    end else begin
                        state_n = RD;
                        cnt_n   = CNT_LOAD;
                    end
                end
            end
            RD: begin
                if (cnt == '0) begin
                    state_n = DONE;
                    rdata_n = sram_data_i;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            WR: begin
                if (cnt == '0) state_n = WR_REC;
                else           cnt_n   = cnt - 1'b1;
            end
            WR_REC:  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes and acks are registered from next-state so the pins never see a
    // combinational path from the request inputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            sram_addr_o  <= '0;
            sram_data_o  <= '0;
            sram_data_oe <= 1'b0;
            sram_we_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            cpu_rdata    <= '0;
            dl_ack       <= 1'b0;
            cpu_ack      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            sram_addr_o  <= addr_n;
            sram_data_o  <= wdata_n;
            cpu_rdata    <= rdata_n;
            sram_oe_n_o  <= (state_n != RD);
            sram_we_n_o  <= (state_n != WR);
            sram_data_oe <= (state_n == WR) || (state_n == WR_REC);
            dl_ack       <= (state_n == DONE) && (state == WR_REC);
            cpu_ack      <= (state_n == DONE) && ((state == RD) || (state == IDLE));
        end
    end

endmodule
